// File: rtl/dip_pkg.sv
// Shared definitions for the DIP frame path: reader FSM encoding,
// grayscale weights and the default frame geometry used by the writers.
package dip_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        READ,
        GAP,
        DONE
    } reader_state_t;

    // Luma weights scaled by 256 (0.299 / 0.587 / 0.114); they sum to 256,
    // so a full-white pixel lands exactly on 255 after the >> 8.
    localparam logic [15:0] GRAY_COEF_R = 16'd77;
    localparam logic [15:0] GRAY_COEF_G = 16'd150;
    localparam logic [15:0] GRAY_COEF_B = 16'd29;

    // Default frame geometry, shared with the SDRAM pixel writers.
    localparam logic [15:0] FRAME_COL_MAX = 16'd1023;
    localparam logic [15:0] FRAME_ROW_MAX = 16'd767;

    // Cycle count within DONE at which the two-stage read/convert pipe is empty.
    localparam logic [1:0] DRAIN_LAST = 2'd2;

endpackage

// File: rtl/rgb565_to_gray.sv
// One registered stage converting an RGB565 word to 8-bit grayscale,
// carrying a valid bit alongside. Usable on either the capture or read path.
module rgb565_to_gray
    import dip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [7:0]  out_data
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] weighted_sum;
    logic [7:0]  gray;

    // Widen each channel to 8 bits by bit replication, then form the weighted sum.
    always_comb begin
        r8           = {in_data[15:11], in_data[15:13]};
        g8           = {in_data[10:5],  in_data[10:9]};
        b8           = {in_data[4:0],   in_data[4:2]};
        weighted_sum = GRAY_COEF_R * {8'd0, r8}
                     + GRAY_COEF_G * {8'd0, g8}
                     + GRAY_COEF_B * {8'd0, b8};
        gray         = 8'(weighted_sum >> 8);
    end

    // Register the converted pixel; the value is only updated when the input is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= gray;
            end
        end
    end

endmodule

// File: rtl/dip_frame_reader.sv
// Replays one stored RGB565 frame from the SDRAM read FIFO as a gapped
// grayscale raster stream for the 3x3 DIP stages.
module dip_frame_reader
    import dip_pkg::*;
#(
    parameter logic [15:0] CNT_COL_MAX = FRAME_COL_MAX,
    parameter logic [15:0] CNT_ROW_MAX = FRAME_ROW_MAX,
    parameter logic [9:0]  LINE_THRESH = 10'd512,
    parameter logic [15:0] LINE_GAP    = 16'd8
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  fifo_rd_usedw,
    output logic        fifo_rd_req,
    input  logic [15:0] fifo_rd_data,
    output logic        dip_en,
    output logic [7:0]  dip_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        underflow
);

    reader_state_t state;
    reader_state_t next_state;

    logic [15:0] col;
    logic [15:0] row;
    logic [15:0] gap_cnt;
    logic [1:0]  drain_cnt;
    logic        req_d1;
    logic        stall;
    logic        line_end;
    logic        last_row;
    logic        gap_end;

    // usedw lags the read port by one cycle, so a count of 1 right after a
    // read really means the FIFO is already empty.
    assign stall    = (fifo_rd_usedw == 10'd0) || ((fifo_rd_usedw == 10'd1) && req_d1);
    assign line_end = (col == CNT_COL_MAX);
    assign last_row = (row == CNT_ROW_MAX);
    assign gap_end  = (gap_cnt >= LINE_GAP - 16'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the read request and frame status outputs.
    always_comb begin
        next_state  = state;
        fifo_rd_req = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                if (fifo_rd_usedw >= LINE_THRESH) begin
                    next_state = READ;
                end
            end
            READ: begin
                if (!stall) begin
                    fifo_rd_req = 1'b1;
                    if (line_end) begin
                        next_state = last_row ? DONE : GAP;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    next_state = WAIT_LINE;
                end
            end
            DONE: begin
                if (drain_cnt == DRAIN_LAST) begin
                    frame_done = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
        frame_busy = (state != IDLE) && !frame_done;
    end

    // Raster position, gap and drain counters, read-request delay and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= 16'd0;
            row       <= 16'd0;
            gap_cnt   <= 16'd0;
            drain_cnt <= 2'd0;
            req_d1    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            req_d1 <= fifo_rd_req;
            case (state)
                IDLE: begin
                    if (start) begin
                        col       <= 16'd0;
                        row       <= 16'd0;
                        gap_cnt   <= 16'd0;
                        drain_cnt <= 2'd0;
                        underflow <= 1'b0;
                    end
                end
                READ: begin
                    if (stall) begin
                        underflow <= 1'b1;
                    end else if (line_end) begin
                        col <= 16'd0;
                        if (!last_row) begin
                            row <= row + 16'd1;
                        end
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_end ? 16'd0 : gap_cnt + 16'd1;
                end
                DONE: begin
                    drain_cnt <= (drain_cnt == DRAIN_LAST) ? 2'd0 : drain_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    rgb565_to_gray u_gray (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (req_d1),
        .in_data   (fifo_rd_data),
        .out_valid (dip_en),
        .out_data  (dip_data)
    );

endmodule

// File: doc/dip_frame_reader.md
# dip_frame_reader

Read-side counterpart of the SDRAM pixel writers in the OV5640_VGA_SOBEL_Ero_Dli datapath. It pulls one stored frame of 16-bit RGB565 words from the SDRAM read FIFO and converts each word to 8-bit grayscale. It replays the result as a gapped raster stream on `dip_en`/`dip_data`, the input format of the 3x3-window DIP stages (erode, dilate, Sobel). This lets a frame already in SDRAM be reprocessed without the camera.

## Interface
Parameters:
- `CNT_COL_MAX`, 16'd1023: last column index; line length is CNT_COL_MAX+1 pixels.
- `CNT_ROW_MAX`, 16'd767: last row index.
- `LINE_THRESH`, 10'd512: minimum FIFO fill level before a line starts.
- `LINE_GAP`, 16'd8: idle cycles inserted after every line except the last.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle frame request.
- `fifo_rd_usedw`  in  10  word count of the SDRAM read FIFO.
- `fifo_rd_req`  out  1  FIFO read request. The FIFO is normal mode, not show-ahead.
- `fifo_rd_data`  in  16  RGB565 word, valid the cycle after `fifo_rd_req`.
- `dip_en`  out  1  pixel valid.
- `dip_data`  out  8  grayscale pixel.
- `frame_busy`  out  1  high from accepted `start` until `frame_done`.
- `frame_done`  out  1  one-cycle pulse after the last pixel is emitted.
- `underflow`  out  1  sticky; set when a read had to stall mid-line.

## Operation
- FSM states:
  - IDLE: `start` moves to WAIT_LINE, zeroes the row/column counters and clears `underflow`.
  - WAIT_LINE: moves to READ when `fifo_rd_usedw >= LINE_THRESH`.
  - READ: asserts `fifo_rd_req` once per issued pixel and increments the column. When the pixel at column CNT_COL_MAX is issued:
    - if row == CNT_ROW_MAX, go to DONE;
    - otherwise increment the row, zero the column and go to GAP.
  - GAP: counts LINE_GAP cycles, then returns to WAIT_LINE.
  - DONE: waits for the 2-stage pipeline to drain, pulses `frame_done`, then returns to IDLE.
- Stall rule in READ: `fifo_rd_req` is held low in a cycle when:
  - `fifo_rd_usedw == 0`, or
  - `fifo_rd_usedw == 1` and `fifo_rd_req` was high in the previous cycle (usedw lags by one cycle).
  - Each stall cycle sets `underflow` and leaves a gap in `dip_en`. The column counter does not advance.
- `start` is ignored when not in IDLE.
- Gray conversion, computed unsigned in 16 bits, with no overflow possible:
  - Expand the channels: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - gray = (77·R8 + 150·G8 + 29·B8) >> 8. The maximum sum is 65280.
- Output ordering: pixels are emitted row-major; the first pixel after `start` is row 0, column 0.
- Reset mid-frame: on the next edge the FSM goes to IDLE, all counters are zeroed and the pipeline is flushed. No further `dip_en` is produced.

## Timing
- Reset values: `fifo_rd_req`=0, `dip_en`=0, `dip_data`=0, `frame_busy`=0, `frame_done`=0, `underflow`=0.
- Latency is 2 cycles:
  - cycle t: `fifo_rd_req` high;
  - t+1: data arrives and is registered;
  - t+2: `dip_en` and `dip_data` are valid from the registered conversion.
- `dip_en` is exactly `fifo_rd_req` delayed by 2 cycles.
- `frame_busy` rises the cycle after `start` is accepted. It falls in the same cycle that `frame_done` is high.
- With no stalls, a line is CNT_COL_MAX+1 consecutive `dip_en` cycles. Consecutive lines are separated by at least LINE_GAP cycles.
- `frame_done` is asserted exactly 1 cycle after the last `dip_en` of row CNT_ROW_MAX.

## Structure
- Shared package `dip_pkg`:
  - FSM state encoding (IDLE, WAIT_LINE, READ, GAP, DONE);
  - the gray coefficients 77/150/29;
  - the default frame dimensions shared with the writers.
- Sub-module `rgb565_to_gray`: one registered stage, 16-bit in, 8-bit out, with a valid bit passed through. It is reusable by the capture path.
- The top level holds the FSM, the row/column/gap counters, the stall logic and the `underflow`/`frame_done` flags.

## Test plan
- Small frame (CNT_COL_MAX=3, CNT_ROW_MAX=1, LINE_GAP=2, LINE_THRESH=4) with the FIFO model kept full; pulse `start`:
  - required: 2 bursts of 4 `dip_en` each, separated by at least 2 idle cycles;
  - `frame_done` 1 cycle after the 8th pixel; `underflow`=0.
- Conversion values:
  - 16'hFFFF → 8'd255;
  - 16'h0000 → 8'd0;
  - 16'hF800 → 8'd76 (77·255>>8);
  - 16'h07E0 → 8'd149;
  - 16'h001F → 8'd28.
- FIFO holds fewer than LINE_THRESH words → `fifo_rd_req` stays 0 in WAIT_LINE until the threshold is reached.
- FIFO drains to 0 mid-line:
  - `fifo_rd_req` drops, `underflow` becomes 1 and the line resumes when data returns;
  - the total pixel count stays 8 and `underflow` stays 1 until the next `start`.
- `start` pulsed again while `frame_busy` → ignored; the frame completes with exactly 8 pixels and one `frame_done`.
- `rst` asserted during row 1 → all outputs are 0 on the next edge and no `dip_en` follows. A fresh `start` then produces a full frame beginning at row 0, column 0.
